vga_pmod_dither_out: RTL

// - Output stage between the raycaster pixel datapath and the Tiny VGA PMOD pins.
// - Reduces COLOR_BITS-per-channel colour to the PMOD's 2 bits per channel, with optional 4x4 ordered dither.
// - Optional temporal dither: a 2-bit frame counter rotates the threshold each frame.
// - Forces black during blanking and delays colour, syncs and blanks through a PIPE_STAGES register pipeline, selectable at run time.

---
 rtl/vga_pmod_dither_out.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vga_pmod_dither_out.sv
// ---------------------------------------------------------------------------
// vga_pmod_dither_out
//
// Output stage between the raycaster pixel datapath and the Tiny VGA PMOD.
// Each COLOR_BITS-wide channel is reduced to 2 bits. The reduction either
// truncates or applies a 4x4 ordered (Bayer) dither. The dither threshold
// can optionally be rotated every frame by a 2-bit frame counter.
// Colour is forced to black while blanking. Colour, syncs and blanks then
// pass through an optional register pipeline that is selected at run time.
//
// Ports
//   clk, rst_n         pixel clock, asynchronous active-low reset
//   i_reg              1: outputs come from pipeline stage PIPE_STAGES
//                      0: outputs come from combinational stage 0
//   i_dither_en        1: ordered dither, 0: truncate
//   i_temporal         1: add {frame,2'b00} to the dither threshold
//   hpos, vpos         current pixel column and row (only bits [1:0] used)
//   hblank, vblank     blanking, active high
//   hsync_n, vsync_n   syncs, active low, passed through unchanged
//   rgb_in             colour packed {B,G,R}, MSB first
//   o_pmod             {hsync_n,B0,G0,R0, vsync_n,B1,G1,R1}
//   o_hblank, o_vblank blanks, delayed by the same latency as o_pmod
//
// There is no valid/ready handshake. Every clock carries one pixel and every
// pipeline stage advances unconditionally.
// ---------------------------------------------------------------------------
module vga_pmod_dither_out #(
  parameter int COLOR_BITS  = 6,
  parameter int PIPE_STAGES = 1,
  parameter int H_BITS      = 10,
  parameter int V_BITS      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_reg,
  input  logic                    i_dither_en,
  input  logic                    i_temporal,
  input  logic [H_BITS-1:0]       hpos,
  input  logic [V_BITS-1:0]       vpos,
  input  logic                    hblank,
  input  logic                    vblank,
  input  logic                    hsync_n,
  input  logic                    vsync_n,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic [7:0]              o_pmod,
  output logic                    o_hblank,
  output logic                    o_vblank
);

  // Frame counter and vblank edge detector
  logic [1:0] frame_q, frame_d;
  logic       vb_prev_q;

  // A 0->1 vblank edge seen at a clock edge advances the frame. The new
  // value is therefore visible from the following cycle onwards.
  assign frame_d = frame_q + {1'b0, vblank & ~vb_prev_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q   <= 2'd0;
      vb_prev_q <= 1'b1;
    end else begin
      frame_q   <= frame_d;
      vb_prev_q <= vblank;
    end
  end

  // Dither threshold. The rows of the matrix are indexed by vpos.
  logic [3:0] bayer_t;
  logic [3:0] thresh;

  always_comb begin
    case ({vpos[1:0], hpos[1:0]})
      4'h0: bayer_t = 4'd0;
      4'h1: bayer_t = 4'd8;
      4'h2: bayer_t = 4'd2;
      4'h3: bayer_t = 4'd10;
      4'h4: bayer_t = 4'd12;
      4'h5: bayer_t = 4'd4;
      4'h6: bayer_t = 4'd14;
      4'h7: bayer_t = 4'd6;
      4'h8: bayer_t = 4'd3;
      4'h9: bayer_t = 4'd11;
      4'ha: bayer_t = 4'd1;
      4'hb: bayer_t = 4'd9;
      4'hc: bayer_t = 4'd15;
      4'hd: bayer_t = 4'd7;
      4'he: bayer_t = 4'd13;
      default: bayer_t = 4'd5;
    endcase
  end

  // The 4-bit add wraps, which gives the required mod-16 rotation.
  assign thresh = i_temporal ? (bayer_t + {frame_q, 2'b00}) : bayer_t;

  // Quantisation. Each channel is left-aligned into 8 bits.
  // [7:6] is the 2-bit value q and [5:2] is the residual. Narrow channels
  // get zero residual bits. With COLOR_BITS==2 the residual is all zero, so
  // the dither can never round up.
  logic [7:0] chan_pad [3];
  logic [1:0] chan_q   [3];
  logic       blank0;
  logic [7:0] word0;

  assign blank0 = hblank | vblank;

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      chan_pad[ch] = 8'(rgb_in[ch*COLOR_BITS +: COLOR_BITS]) << (8 - COLOR_BITS);
      chan_q[ch]   = chan_pad[ch][7:6];
      // Round up only when there is headroom. A full-scale channel saturates.
      if (i_dither_en && (chan_pad[ch][5:2] > thresh) && (chan_q[ch] != 2'd3)) begin
        chan_q[ch] = chan_q[ch] + 2'd1;
      end
      if (blank0) begin
        chan_q[ch] = 2'd0;
      end
    end
  end

  // Channel index 0=R, 1=G, 2=B
  assign word0 = {hsync_n, chan_q[2][0], chan_q[1][0], chan_q[0][0],
                  vsync_n, chan_q[2][1], chan_q[1][1], chan_q[0][1]};

  // Output pipeline. Stage i holds the word delayed by i+1 clocks.
  logic [7:0]             word_q [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] hblank_q;
  logic [PIPE_STAGES-1:0] vblank_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        word_q[i] <= 8'h88;
      end
      hblank_q <= '1;
      vblank_q <= '1;
    end else begin
      word_q[0]   <= word0;
      hblank_q[0] <= hblank;
      vblank_q[0] <= vblank;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        word_q[i]   <= word_q[i-1];
        hblank_q[i] <= hblank_q[i-1];
        vblank_q[i] <= vblank_q[i-1];
      end
    end
  end

  // The source switches immediately. A glitch on toggle is acceptable.
  assign o_pmod   = i_reg ? word_q[PIPE_STAGES-1]   : word0;
  assign o_hblank = i_reg ? hblank_q[PIPE_STAGES-1] : hblank;
  assign o_vblank = i_reg ? vblank_q[PIPE_STAGES-1] : vblank;

  // Position bits above the 4x4 tile and the alignment padding carry no
  // information for this stage.
  logic unused_bits;
  assign unused_bits = ^{hpos[H_BITS-1:2], vpos[V_BITS-1:2],
                         chan_pad[0][1:0], chan_pad[1][1:0], chan_pad[2][1:0]};

endmodule
